// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, controller states,
// and byte-enable patterns.
package mips_mem_pkg;

    localparam logic [1:0] MEMSIZE_WORD = 2'b00;
    localparam logic [1:0] MEMSIZE_HALF = 2'b01;
    localparam logic [1:0] MEMSIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return BE_BYTE0 << lane;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for the data port: store replication, byte enables,
// load extract/extend and alignment detection. Sub-word support under MEM_SUBWORD_EN.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_memsize,
    input  logic        i_memunsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

`ifdef MEM_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata    = i_wdata;
        o_be       = BE_WORD;
        o_rdata    = i_rdata;
        o_misalign = 1'b0;
        w_byte     = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_memsize)
            MEMSIZE_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = byte_be(i_addr_lo);
                o_rdata = i_memunsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            MEMSIZE_HALF: begin
                o_wdata    = {2{i_wdata[15:0]}};
                o_be       = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_rdata    = i_memunsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            default: begin
                o_misalign = |i_addr_lo;
            end
        endcase
    end
`else
    // Word-only build: size and signedness controls have no effect.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{i_memsize, i_memunsigned};

    assign o_wdata    = i_wdata;
    assign o_be       = BE_WORD;
    assign o_rdata    = i_rdata;
    assign o_misalign = |i_addr_lo;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: sequences one data-memory access per load/store and stalls
// the front of the pipe until it completes. Sub-word accesses need MEM_SUBWORD_EN.
//
// state     | meaning
// ST_IDLE   | no access in flight; an aligned load/store starts one
// ST_ACCESS | request held on the data port until dmem_ack
// ST_DONE   | one cycle, stall released so MEM/WB captures read_data_M
module mem_stage
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_M,
    input  logic        memwrite_M,
    input  logic [1:0]  memsize_M,
    input  logic        memunsigned_M,
    input  logic [31:0] aluout_M,
    input  logic [31:0] writedata_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_data_M,
    output logic        stall_M,
    output logic        misalign_M
);

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;
    logic [31:0] r_read_data;
    logic [31:0] w_load_data;
    logic        w_memop;
    logic        w_misalign_raw;
    logic        w_capture;

    mem_lane_align u_lane (
        .i_memsize     (memsize_M),
        .i_memunsigned (memunsigned_M),
        .i_addr_lo     (aluout_M[1:0]),
        .i_wdata       (writedata_M),
        .i_rdata       (dmem_rdata),
        .o_wdata       (dmem_wdata),
        .o_be          (dmem_be),
        .o_rdata       (w_load_data),
        .o_misalign    (w_misalign_raw)
    );

    assign w_memop    = memread_M | memwrite_M;
    assign misalign_M = w_memop & w_misalign_raw;
    assign dmem_addr  = {aluout_M[31:2], 2'b00};
    assign w_capture  = (r_state == ST_ACCESS) & dmem_ack & memread_M;

    // A faulting access reports zero; the captured value survives for later reads.
    assign read_data_M = misalign_M ? 32'h0 : r_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_read_data <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_read_data <= w_load_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        stall_M     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && !w_misalign_raw) begin
                    stall_M     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dmem_req = 1'b1;
                dmem_we  = memwrite_M;
                stall_M  = 1'b1;
                if (dmem_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores push expectations, a
// negedge monitor checks the data port and the completed result.
module tb_mem_stage;
    import mips_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        memread_M;
    logic        memwrite_M;
    logic [1:0]  memsize_M;
    logic        memunsigned_M;
    logic [31:0] aluout_M;
    logic [31:0] writedata_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] read_data_M;
    logic        stall_M;
    logic        misalign_M;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .memread_M     (memread_M),
        .memwrite_M    (memwrite_M),
        .memsize_M     (memsize_M),
        .memunsigned_M (memunsigned_M),
        .aluout_M      (aluout_M),
        .writedata_M   (writedata_M),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .read_data_M   (read_data_M),
        .stall_M       (stall_M),
        .misalign_M    (misalign_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_be;
        logic        chk_rd;
        logic [31:0] rd;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   stall_cnt = 0;
    logic acked = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    endtask

    task automatic fail_now(input string nm);
        n_tot++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Monitor: data-port fields every request cycle, result and stall count on completion.
    always @(negedge clk) begin
        if (!mon_en || reset) begin
            stall_cnt = 0;
            acked     = 1'b0;
        end else begin
            if (acked && !stall_M) begin
                if (sb_q.size() == 0) begin
                    fail_now("sb_underflow_done");
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.chk_rd) chk("read_data", read_data_M, mon_e.rd);
                    chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
                end
                acked     = 1'b0;
                stall_cnt = 0;
            end
            if (stall_M) stall_cnt++;
            if (dmem_req) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_req");
                end else begin
                    mon_e = sb_q[0];
                    chk("dmem_we", {31'h0, dmem_we}, {31'h0, mon_e.we});
                    chk("dmem_addr", dmem_addr, mon_e.addr);
                    if (mon_e.we) chk("dmem_wdata", dmem_wdata, mon_e.wdata);
                    if (mon_e.chk_be) chk("dmem_be", {28'h0, dmem_be}, {28'h0, mon_e.be});
                end
                if (dmem_ack) acked = 1'b1;
            end
        end
    end

    // Entered and left at posedge+1 with the controller idle.
    task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                          input int dly, input logic [3:0] be, input logic chk_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        exp_t e;
        e.we     = wr;
        e.addr   = addr & 32'hFFFF_FFFC;
        e.wdata  = exp_wd;
        e.be     = be;
        e.chk_be = chk_be;
        e.chk_rd = rd;
        e.rd     = exp_rd;
        e.stalls = dly + 2;
        sb_q.push_back(e);
        memread_M     = rd;
        memwrite_M    = wr;
        memsize_M     = sz;
        memunsigned_M = uns;
        aluout_M      = addr;
        writedata_M   = wd;
        @(posedge clk); #1;
        repeat (dly) begin
            @(posedge clk); #1;
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        memread_M  = 1'b0;
        memwrite_M = 1'b0;
    endtask

    task automatic misalign_op(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic [31:0] addr);
        memread_M   = rd;
        memwrite_M  = wr;
        memsize_M   = sz;
        aluout_M    = addr;
        writedata_M = 32'hCAFE_F00D;
        repeat (2) begin
            @(negedge clk);
            chk({nm, "_misalign"}, {31'h0, misalign_M}, 32'h1);
            chk({nm, "_req"}, {31'h0, dmem_req}, 32'h0);
            chk({nm, "_stall"}, {31'h0, stall_M}, 32'h0);
            chk({nm, "_rdata"}, read_data_M, 32'h0);
            @(posedge clk); #1;
        end
        memread_M  = 1'b0;
        memwrite_M = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        memread_M     = 1'b0;
        memwrite_M    = 1'b0;
        memsize_M     = MEMSIZE_WORD;
        memunsigned_M = 1'b0;
        aluout_M      = 32'h0;
        writedata_M   = 32'h0;
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_stall", {31'h0, stall_M}, 32'h0);
        chk("rst_rdata", read_data_M, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // lw 0x100, immediate ack
        mem_op(1, 0, MEMSIZE_WORD, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, BE_WORD, 1, 32'h0, 32'hDEAD_BEEF);

        // idle cycle holds the last load; stray ack is ignored
        @(negedge clk);
        chk("hold_rdata", read_data_M, 32'hDEAD_BEEF);
        chk("hold_stall", {31'h0, stall_M}, 32'h0);
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("stray_ack_req", {31'h0, dmem_req}, 32'h0);
        chk("stray_ack_stall", {31'h0, stall_M}, 32'h0);
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("stray_ack_rdata", read_data_M, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // sw 0x204, ack after 2 wait cycles
        mem_op(0, 1, MEMSIZE_WORD, 0, 32'h204, 32'h1234_5678, 32'h0, 2, BE_WORD, 1, 32'h1234_5678, 32'h0);
        // lw 0x3F8, one wait cycle
        mem_op(1, 0, MEMSIZE_WORD, 0, 32'h3F8, 32'h0, 32'h0F0F_1234, 1, BE_WORD, 1, 32'h0, 32'h0F0F_1234);

        misalign_op("lw101", 1, 0, MEMSIZE_WORD, 32'h101);

`ifdef MEM_SUBWORD_EN
        mem_op(1, 0, MEMSIZE_BYTE, 0, 32'h103, 32'h0, 32'h8011_2233, 0, 4'h0, 0, 32'h0, 32'hFFFF_FF80);
        mem_op(1, 0, MEMSIZE_BYTE, 1, 32'h103, 32'h0, 32'h8011_2233, 0, 4'h0, 0, 32'h0, 32'h0000_0080);
        mem_op(1, 0, MEMSIZE_BYTE, 0, 32'h101, 32'h0, 32'h8011_2233, 0, 4'h0, 0, 32'h0, 32'h0000_0022);
        mem_op(0, 1, MEMSIZE_HALF, 0, 32'h102, 32'h0000_ABCD, 32'h0, 3, BE_HALF_HI, 1, 32'hABCD_ABCD, 32'h0);
        mem_op(0, 1, MEMSIZE_BYTE, 0, 32'h101, 32'h0000_005A, 32'h0, 0, 4'b0010, 1, 32'h5A5A_5A5A, 32'h0);
        mem_op(0, 1, MEMSIZE_HALF, 0, 32'h200, 32'h7777_BEEF, 32'h0, 1, BE_HALF_LO, 1, 32'hBEEF_BEEF, 32'h0);
        mem_op(1, 0, MEMSIZE_HALF, 0, 32'h102, 32'h0, 32'h8001_1234, 0, 4'h0, 0, 32'h0, 32'hFFFF_8001);
        mem_op(1, 0, MEMSIZE_HALF, 1, 32'h100, 32'h0, 32'h1234_F00D, 0, 4'h0, 0, 32'h0, 32'h0000_F00D);
        misalign_op("lh101", 1, 0, MEMSIZE_HALF, 32'h101);
        misalign_op("sh103", 0, 1, MEMSIZE_HALF, 32'h103);
`else
        mem_op(1, 0, MEMSIZE_BYTE, 0, 32'h100, 32'h0, 32'h8011_2233, 0, BE_WORD, 1, 32'h0, 32'h8011_2233);
        mem_op(0, 1, MEMSIZE_HALF, 0, 32'h108, 32'h0000_ABCD, 32'h0, 3, BE_WORD, 1, 32'h0000_ABCD, 32'h0);
        misalign_op("sh102", 0, 1, MEMSIZE_HALF, 32'h102);
        misalign_op("lbu103", 1, 0, MEMSIZE_BYTE, 32'h103);
`endif

        // reset in the second ACCESS cycle, ack arrives the cycle after
        mon_en        = 1'b0;
        memread_M     = 1'b1;
        memsize_M     = MEMSIZE_WORD;
        memunsigned_M = 1'b0;
        aluout_M      = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req_before", {31'h0, dmem_req}, 32'h1);
        chk("rst_mid_rdata_before_nz", {31'h0, (read_data_M != 32'h0)}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rst_mid_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_mid_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_mid_stall_idle", {31'h0, stall_M}, 32'h1);
        chk("rst_mid_rdata", read_data_M, 32'h0);
        memread_M = 1'b0;
        dmem_ack  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_after_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_after_stall", {31'h0, stall_M}, 32'h0);
        chk("rst_after_rdata", read_data_M, 32'h0);
        @(posedge clk); #1;

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
